// File: rtl/regfile.sv
// 32-entry MIPS-style register file: two combinational read ports, one clocked
// write port, register 0 hardwired to zero, optional same-cycle write bypass.
module regfile #(
  parameter int WIDTH  = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rsNum,
  input  logic [4:0]       rtNum,
  output logic [WIDTH-1:0] rsData,
  output logic [WIDTH-1:0] rtData,
  input  logic [4:0]       rdNum,
  input  logic [WIDTH-1:0] rdData,
  input  logic             rdWriteEnable
);

  logic [31:0]      write_sel;
  logic [WIDTH-1:0] store [1:31];
  logic [WIDTH-1:0] view  [32];

  always_comb begin
    write_sel        = '0;
    write_sel[rdNum] = rdWriteEnable;
    write_sel[0]     = 1'b0;
  end

  // Entry 0 has no flop; each remaining entry is an enabled register.
  for (genvar i = 1; i < 32; i++) begin : g_entry
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        store[i] <= '0;
      else if (write_sel[i])
        store[i] <= rdData;
    end
  end

  always_comb begin
    view[0] = '0;
    for (int i = 1; i < 32; i++)
      view[i] = store[i];
  end

  // Reset gating comes last so it also masks the bypass path.
  always_comb begin
    rsData = view[rsNum];
    if (BYPASS && rdWriteEnable && (rdNum == rsNum) && (rsNum != 5'd0))
      rsData = rdData;
    if (reset)
      rsData = '0;
  end

  always_comb begin
    rtData = view[rtNum];
    if (BYPASS && rdWriteEnable && (rdNum == rtNum) && (rtNum != 5'd0))
      rtData = rdData;
    if (reset)
      rtData = '0;
  end

endmodule
